mult_sweep_eval: RTL

//  - Synthesizable exhaustive-sweep evaluator for approximate multipliers.
//  - Drives every operand pair (a,b) in [0,2^W)^2 into an external multiplier DUT of fixed latency LAT.
//  - Compares each DUT result against the exact product and accumulates error statistics:
//    sum of |ED|, mismatch count and maximum |ED|.
//  - MRED/NMED are post-processed off-chip from these statistics. Instantiated next to mult_wrapper on FPGA/ASIC test builds.

---
 rtl/mult_eval_pkg.sv | 17 +
 rtl/mult_sweep_eval_if.sv | 11 +
 rtl/mult_eval_delay.sv | 41 ++++
 rtl/mult_sweep_eval.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mult_eval_pkg.sv
// rtl/mult_eval_pkg.sv - shared types, defaults and helpers for the multiplier sweep evaluator
package mult_eval_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} eval_state_e;

  localparam int DEF_W   = 8;
  localparam int DEF_LAT = 3;

  // Wide enough for any product width up to 32 bits; callers cast down to 2W.
  localparam int ABS_W = 33;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                input logic [ABS_W-1:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/mult_sweep_eval_if.sv
// rtl/mult_sweep_eval_if.sv - operand/product bus between the evaluator and the multiplier under test
interface mult_sweep_eval_if #(parameter int W = 8);

  logic [W-1:0]   inA;
  logic [W-1:0]   inB;
  logic [2*W-1:0] Y;

  modport master (output inA, output inB, input Y);
  modport slave  (input inA, input inB, output Y);

endinterface

// File: rtl/mult_eval_delay.sv
// rtl/mult_eval_delay.sv - valid + data shift register matching the multiplier latency
module mult_eval_delay #(
  parameter int DW  = 16,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (LAT == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [DW-1:0]  dat_q [LAT];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= in_valid;
          dat_q[0] <= in_data;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_valid = vld_q[LAT-1];
      assign out_data  = dat_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mult_sweep_eval.sv
// rtl/mult_sweep_eval.sv - exhaustive operand sweep and error statistics; MAXED_TRACK_EN enables worst-pair capture
module mult_sweep_eval
  import mult_eval_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LAT   = DEF_LAT,
  parameter int SUM_W = 4 * W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  mult_sweep_eval_if.master   bus,
  output logic [SUM_W-1:0]    err_sum,
  output logic [2*W:0]        mis_cnt,
  output logic [2*W-1:0]      max_ed,
  output logic [W-1:0]        worst_a,
  output logic [W-1:0]        worst_b
);

  localparam int PW = 2 * W;
  localparam int MW = PW + 1;
`ifdef MAXED_TRACK_EN
  localparam int DLW = 2 * PW;
`else
  localparam int DLW = PW;
`endif
  localparam logic [3:0] DRAIN_LAST = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  eval_state_e    state_q, state_d;
  logic [PW-1:0]  cnt_q;
  logic [3:0]     drain_q;
  logic           issue, clear, last_issue, drain_end, held;
  logic [PW-1:0]  exp_in, exp_out, ed;
  logic [DLW-1:0] dl_in, dl_out;
  logic           dl_valid;

  assign last_issue = issue && (cnt_q == '1);
  assign drain_end  = (drain_q == DRAIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)      state_d = SWEEP;
      SWEEP:      if (last_issue) state_d = DRAIN;
      DRAIN:      if (drain_end)  state_d = DONE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    clear = 1'b0;
    unique case (state_q)
      IDLE:  clear = start;
      SWEEP: begin busy = 1'b1; issue = 1'b1; end
      DRAIN: busy = 1'b1;
      DONE:  begin done = 1'b1; clear = start; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      if (clear)      cnt_q <= '0;
      else if (issue) cnt_q <= cnt_q + PW'(1);
      drain_q <= (state_q == DRAIN) ? drain_q + 4'd1 : 4'd0;
    end
  end

  // Only a completed sweep reaches DRAIN/DONE, so the last issued pair is always all ones.
  assign held    = (state_q == DRAIN) || (state_q == DONE);
  assign bus.inA = held ? '1 : cnt_q[PW-1:W];
  assign bus.inB = held ? '1 : cnt_q[W-1:0];

  assign exp_in = {{W{1'b0}}, cnt_q[PW-1:W]} * {{W{1'b0}}, cnt_q[W-1:0]};
`ifdef MAXED_TRACK_EN
  assign dl_in = {cnt_q, exp_in};
`else
  assign dl_in = exp_in;
`endif

  mult_eval_delay #(.DW(DLW), .LAT(LAT)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .in_valid (issue),
    .in_data  (dl_in),
    .out_valid(dl_valid),
    .out_data (dl_out)
  );

  assign exp_out = dl_out[PW-1:0];
  assign ed      = PW'(abs_diff(ABS_W'(bus.Y), ABS_W'(exp_out)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      err_sum <= '0;
      mis_cnt <= '0;
      max_ed  <= '0;
    end else if (dl_valid) begin
      err_sum <= err_sum + SUM_W'(ed);
      if (ed != '0)    mis_cnt <= mis_cnt + MW'(1);
      if (ed > max_ed) max_ed  <= ed;
    end
  end

`ifdef MAXED_TRACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      worst_a <= '0;
      worst_b <= '0;
    end else if (dl_valid && (ed > max_ed)) begin
      worst_a <= dl_out[DLW-1:DLW-W];
      worst_b <= dl_out[PW+W-1:PW];
    end
  end
`else
  assign worst_a = '0;
  assign worst_b = '0;
`endif

endmodule
